// File: rtl/prbs15_byte_gen.sv
// Byte-wide PRBS15 (x^15 + x^14 + 1) pattern generator for the loopback link.
// Emits 8 sequence bits per clock with burst/continuous runs and bit-0 error injection.
module prbs15_byte_gen #(
  parameter logic [14:0] DEFAULT_SEED = 15'h7FFF,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [14:0]      seed_in,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             inject_err,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_sent,
  output logic [15:0]      err_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]      ERR_MAX  = 16'hFFFF;

  state_t           state;
  state_t           state_next;

  // history[14] is the oldest bit x[n-15], history[0] the newest x[n-1]
  logic [14:0]      history;
  logic [14:0]      next_history;
  logic [7:0]       next_byte;

  logic [CNT_W-1:0] remaining;
  logic             pending_err;
  logic             last_byte;
  logic             emit;

  // Eight sequence steps unrolled in one cycle.
  // NOTE: blocking assignments inside always_comb let each loop iteration see the
  // history produced by the previous one; every variable gets a default first so
  // no latch is inferred.
  always_comb begin
    next_history = history;
    next_byte    = '0;
    for (int k = 0; k < 8; k++) begin
      next_byte[7-k] = next_history[14] ^ next_history[13];
      next_history   = {next_history[13:0], next_byte[7-k]};
    end
  end

  // A burst ends when the byte being registered is the last one counted down.
  // Continuous runs keep remaining at zero, so they never match here.
  assign last_byte = (remaining == CNT_ONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop || last_byte) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    emit = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        emit = 1'b0;
      end
      RUN: begin
        busy = 1'b1;
        emit = 1'b1;
      end
      default: begin
        busy = 1'b0;
        emit = 1'b0;
      end
    endcase
  end

  // Datapath: history, output byte, burst counter, error injection and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      history     <= DEFAULT_SEED;
      data_out    <= '0;
      data_valid  <= 1'b0;
      remaining   <= CNT_ZERO;
      pending_err <= 1'b0;
      bytes_sent  <= CNT_ZERO;
      err_count   <= '0;
    end else begin
      data_valid <= emit;
      // A pulse arriving while the pending flag is being consumed re-arms it.
      pending_err <= inject_err | (pending_err & ~emit);

      if (emit) begin
        // Only the output copy is corrupted; history keeps the true sequence.
        data_out   <= next_byte ^ {7'b0, pending_err};
        history    <= next_history;
        bytes_sent <= bytes_sent + CNT_ONE;
        if (remaining != CNT_ZERO) begin
          remaining <= remaining - CNT_ONE;
        end
        if (pending_err && (err_count != ERR_MAX)) begin
          err_count <= err_count + 16'd1;
        end
      end else begin
        data_out <= '0;
        // An all-zero history would lock the sequence at zero forever.
        if (seed_load) begin
          history <= (seed_in == 15'd0) ? DEFAULT_SEED : seed_in;
        end
        if (start) begin
          remaining <= burst_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs15_byte_gen.sv
// Randomised scoreboard bench for prbs15_byte_gen against a bit-level sequence model.
// Stimulus pushes expected bytes; a negedge monitor pops and compares every valid byte.
module tb_prbs15_byte_gen;

  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic             seed_load;
  logic [14:0]      seed_in;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] burst_len;
  logic             inject_err;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             busy;
  logic [CNT_W-1:0] bytes_sent;
  logic [15:0]      err_count;

  prbs15_byte_gen #(
    .DEFAULT_SEED(15'h7FFF),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .inject_err(inject_err),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .bytes_sent(bytes_sent),
    .err_count (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the sequence as a list of bits, x[n] = x[n-14] ^ x[n-15].
  bit          model_bits[$];
  logic [7:0]  exp_q[$];
  int          model_errs;
  int unsigned model_sent;
  bit          model_pend;
  bit          inj_set[int];

  // Capture-side self-synchronising check, enabled for the long run only.
  bit          ss_en;
  bit          rx_bits[$];
  int          ss_errs;

  task automatic model_seed(input logic [14:0] s);
    logic [14:0] sv;
    sv = (s == 15'd0) ? 15'h7FFF : s;
    model_bits.delete();
    for (int i = 0; i < 15; i++) model_bits.push_back(sv[14-i]);
  endtask

  task automatic model_byte(output logic [7:0] b);
    bit nb;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      nb = model_bits[$-13] ^ model_bits[$-14];
      model_bits.push_back(nb);
      void'(model_bits.pop_front());
      b[7-k] = nb;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    seed_load  = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    inject_err = 1'b0;
  endtask

  task automatic model_reset();
    model_seed(15'h7FFF);
    exp_q.delete();
    model_errs = 0;
    model_sent = 0;
    model_pend = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check(name, exp_q.size(), 0);
  endtask

  // One run of n bytes; inj_set holds byte indices whose cycle carries inject_err.
  task automatic run_seq(input int n, input bit cont, input bit stop_last,
                         input bit with_seed, input logic [14:0] seed);
    logic [7:0] b;
    if (with_seed) model_seed(seed);
    for (int i = 0; i < n; i++) begin
      model_byte(b);
      if (model_pend) begin
        b[0] = ~b[0];
        model_errs++;
      end
      model_pend = inj_set.exists(i);
      exp_q.push_back(b);
    end
    model_sent += n;

    burst_len = cont ? '0 : CNT_W'(n);
    start     = 1'b1;
    seed_load = with_seed;
    seed_in   = seed;
    tick();
    clear_inputs();
    burst_len = $urandom;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      inject_err = inj_set.exists(i);
      stop       = cont ? (i == n-1) : (stop_last && i == n-1);
      seed_load  = ($urandom_range(0, 3) == 0);
      seed_in    = 15'($urandom);
      tick();
    end
    clear_inputs();
    check("busy_after_run", busy, 0);
  endtask

  task automatic known_vector();
    logic [7:0] b;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h0C);
    for (int i = 0; i < 4; i++) model_byte(b);
    model_sent += 4;
    burst_len = 4;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("kv_valid_at_start", data_valid, 0);
    check("kv_busy_after_start", busy, 1);
    tick();
    check("kv_first_valid", data_valid, 1);
    check("kv_first_byte", data_out, 8'h00);
    tick();
    tick();
    tick();
    check("kv_busy_last", busy, 0);
    check("kv_valid_last", data_valid, 1);
    tick();
    check("kv_valid_drop", data_valid, 0);
    check("kv_bytes_sent", bytes_sent, model_sent);
  endtask

  // Monitor: compares every presented byte against the scoreboard head.
  initial begin
    logic [7:0] e;
    bit         b;
    forever begin
      @(negedge clk);
      if (!reset && data_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'h0, data_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("data_out", data_out, e);
        end
        if (ss_en) begin
          for (int k = 0; k < 8; k++) begin
            b = data_out[7-k];
            if (rx_bits.size() >= 15 && ((rx_bits[$-13] ^ rx_bits[$-14]) != b)) ss_errs++;
            rx_bits.push_back(b);
            if (rx_bits.size() > 15) void'(rx_bits.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    seed_in   = '0;
    burst_len = '0;
    ss_en     = 1'b0;
    ss_errs   = 0;
    clear_inputs();
    do_reset();

    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_bytes_sent", bytes_sent, 0);
    check("rst_err_count", err_count, 0);

    known_vector();
    drain("drain_kv");

    // Zero seed falls back to the default seed; seed_load and start together.
    inj_set.delete();
    seed_in   = 15'h0;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    model_seed(15'h0);
    run_seq(1, 1'b0, 1'b0, 1'b0, 15'h0);
    run_seq(3, 1'b0, 1'b0, 1'b1, 15'h1234);
    drain("drain_seed");

    // Two bursts separated by idle cycles continue one sequence.
    run_seq(3, 1'b0, 1'b0, 1'b0, 15'h0);
    repeat (5) tick();
    run_seq(3, 1'b0, 1'b1, 1'b0, 15'h0);
    drain("drain_split");

    // Stop sampled with the second byte: exactly two bytes.
    run_seq(2, 1'b1, 1'b0, 1'b0, 15'h0);
    repeat (3) tick();
    drain("drain_stop2");

    // Inject during the 10th byte of a continuous run.
    begin
      int e0;
      e0 = model_errs;
      inj_set.delete();
      inj_set[9] = 1'b1;
      run_seq(40, 1'b1, 1'b0, 1'b0, 15'h0);
      inj_set.delete();
      drain("drain_inj");
      check("inj_err_delta", model_errs - e0, 1);
      check("inj_err_count", err_count, model_errs);
    end

    // Idle pulses collapse to a single error on the next byte.
    inject_err = 1'b1;
    tick();
    tick();
    inject_err = 1'b0;
    model_pend = 1'b1;
    run_seq(4, 1'b0, 1'b0, 1'b0, 15'h0);
    // Back-to-back pulses re-arm: bytes 4 and 5 both flipped.
    inj_set[3] = 1'b1;
    inj_set[4] = 1'b1;
    run_seq(8, 1'b1, 1'b0, 1'b0, 15'h0);
    inj_set.delete();
    drain("drain_rearm");
    check("rearm_err_count", err_count, model_errs);

    // Reset mid-burst with a pending error discards everything.
    begin
      logic [7:0] b;
      for (int i = 0; i < 10; i++) begin
        model_byte(b);
        exp_q.push_back(b);
      end
      burst_len = 10;
      start     = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      inject_err = 1'b1;
      tick();
      inject_err = 1'b0;
      reset      = 1'b1;
      tick();
      check("midrst_data_out", data_out, 0);
      check("midrst_data_valid", data_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_err_count", err_count, 0);
      check("midrst_bytes_sent", bytes_sent, 0);
      reset = 1'b0;
      model_reset();
      tick();
      check("postrst_data_valid", data_valid, 0);
      known_vector();
      drain("drain_postrst");
    end

    // Long continuous run also checked by a self-synchronising receiver.
    rx_bits.delete();
    ss_errs = 0;
    ss_en   = 1'b1;
    run_seq(40000, 1'b1, 1'b0, 1'b0, 15'h0);
    drain("drain_long");
    ss_en = 1'b0;
    check("selfsync_errors", ss_errs, 0);

    // Randomised mix of bursts, stops, seeds and injections.
    for (int it = 0; it < 40; it++) begin
      int  n;
      bit  cont;
      n    = $urandom_range(1, 12);
      cont = $urandom_range(0, 1);
      inj_set.delete();
      for (int j = 0; j < $urandom_range(0, 2); j++) inj_set[$urandom_range(0, n-1)] = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        inject_err = 1'b1;
        tick();
        inject_err = 1'b0;
        model_pend = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        seed_in   = 15'($urandom);
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        model_seed(seed_in);
      end
      run_seq(n, cont, $urandom_range(0, 1), $urandom_range(0, 3) == 0, 15'($urandom));
      repeat ($urandom_range(0, 4)) tick();
    end
    inj_set.delete();
    drain("drain_rand");

    check("final_bytes_sent", bytes_sent, model_sent);
    check("final_err_count", err_count, model_errs);
    check("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
